// File: rtl/y86_dmem_responder.sv
// y86_dmem_responder
//   Data-memory responder for the Y86 memory stage. Takes one 64-bit read or
//   write at a time over valid/ready, spends WAIT_STATES cycles in WAIT, then
//   returns read data (valM) or a write acknowledgement as a one-cycle pulse.
//   Out-of-range accesses respond with dmem_error=1 and rdata=0 and leave the
//   store untouched.
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req_valid     request present            req_ready   request accepted when both high
//   req_write     1 = write, 0 = read        req_addr    byte address (unaligned ok)
//   req_wdata     write data (valA)
//   resp_valid    one-cycle response pulse   resp_rdata  read data, 0 for writes/errors
//   dmem_error    address out of range, qualified by resp_valid
module y86_dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        dmem_error
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  // Highest legal start address; comparing against it avoids forming addr+8.
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          req_ready_nxt;
  logic          resp_valid_nxt;
  logic [63:0]   resp_rdata_nxt;
  logic          dmem_error_nxt;

  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic          accept_c;
  logic          enter_resp_c;
  logic          acc_write_c;
  logic [63:0]   acc_addr_c;
  logic [63:0]   acc_wdata_c;
  logic [AW-1:0] acc_idx_c;
  logic          range_err_c;
  logic          commit_c;
  logic [63:0]   rd_word_c;

  logic [7:0]    mem [DEPTH_BYTES];

  assign accept_c     = req_valid && req_ready && (state == IDLE);
  assign enter_resp_c = (state_nxt == RESP) && (state != RESP);

  // With WAIT_STATES=0 the access happens on the accept edge, so use the
  // live request instead of the latched copy.
  assign acc_write_c = (state == IDLE) ? req_write : lat_write;
  assign acc_addr_c  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata_c = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_idx_c   = acc_addr_c[AW-1:0];
  assign range_err_c = acc_addr_c > MAX_ADDR;
  assign commit_c    = enter_resp_c && acc_write_c && !range_err_c;

  // Little-endian gather of the 8 bytes starting at the access address.
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word_c[8*i +: 8] = mem[acc_idx_c + AW'(i)];
    end
  end

  // Backing store: not reset; all 8 bytes commit on the edge entering RESP.
  // The rst gate drops a commit racing an asynchronous reset.
  always_ff @(posedge clk) begin
    if (commit_c && !rst) begin
      for (int i = 0; i < 8; i++) begin
        mem[acc_idx_c + AW'(i)] <= acc_wdata_c[8*i +: 8];
      end
    end
  end

  // Request capture and access result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept_c) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (enter_resp_c) begin
        rdata_q <= (acc_write_c || range_err_c) ? 64'd0 : rd_word_c;
        err_q   <= range_err_c;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      dmem_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      dmem_error <= dmem_error_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    req_ready_nxt  = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = resp_rdata;
    dmem_error_nxt = dmem_error;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(1);
          end
        end else begin
          req_ready_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CW'(WAIT_STATES)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        // Response pulse lands in the cycle after RESP; ready stays low
        // through it and rises one cycle later.
        state_nxt      = IDLE;
        resp_valid_nxt = 1'b1;
        resp_rdata_nxt = rdata_q;
        dmem_error_nxt = err_q;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: one instance with WAIT_STATES=2 and one with
// WAIT_STATES=0, checked against a byte-array reference model.
module tb_y86_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        dmem_error [2];

  logic [7:0]  mem_m [2][DEPTH];
  int          wait_st [2] = '{2, 0};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  y86_dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .dmem_error(dmem_error[0])
  );

  y86_dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .dmem_error(dmem_error[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input int d, input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_m[d][int'(a) + i];
    return w;
  endfunction

  function automatic bit in_range(input logic [63:0] a);
    return a <= 64'(DEPTH - 8);
  endfunction

  // Waits up to 50 cycles for ready; reports a failed comparison on timeout.
  task automatic wait_ready(input int d, output bit ok);
    int k;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready[d];
    if (!ok) check("ready_timeout", 64'(req_ready[d]), 64'd1);
  endtask

  // One full transaction. hold=1 keeps req_valid high with scrambled fields
  // while busy; those must be ignored.
  task automatic txn(input int d, input logic wr, input logic [63:0] a,
                     input logic [63:0] wd, input bit hold, output logic [63:0] got);
    int k;
    bit seen, ok;
    logic [63:0] exp_rd;
    logic exp_err;
    got = '0;
    wait_ready(d, ok);
    if (!ok) return;
    exp_err = !in_range(a);
    exp_rd  = (wr || exp_err) ? 64'd0 : model_read(d, a);
    if (wr && !exp_err)
      for (int i = 0; i < 8; i++) mem_m[d][int'(a) + i] = wd[8*i +: 8];
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      check("busy_ready", 64'(req_ready[d]), 64'd0);
      if (resp_valid[d]) seen = 1'b1;
      if (hold && !seen) begin
        req_write[d] = 1'($urandom);
        req_addr[d]  = 64'($urandom_range(0, DEPTH - 8));
        req_wdata[d] = {$urandom, $urandom};
      end else begin
        req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    check("resp_seen", 64'(seen), 64'd1);
    check("latency_edges", 64'(k - 1), 64'(wait_st[d] + 1));
    check("rdata", resp_rdata[d], exp_rd);
    check("err", 64'(dmem_error[d]), 64'(exp_err));
    got = resp_rdata[d];
    @(negedge clk);
    check("pulse_end", 64'(resp_valid[d]), 64'd0);
    check("rdata_hold", resp_rdata[d], exp_rd);
    check("err_hold", 64'(dmem_error[d]), 64'(exp_err));
    check("ready_back", 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    logic [63:0] got, pre, a;
    bit ok;
    logic wr;
    int d, sel;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 64'(req_ready[i]), 64'd1);
      check("rst_valid", 64'(resp_valid[i]), 64'd0);
      check("rst_rdata", resp_rdata[i], 64'd0);
      check("rst_err", 64'(dmem_error[i]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Give the store known contents.
    for (int dd = 0; dd < 2; dd++)
      for (int ad = 0; ad < int'(DEPTH); ad += 8)
        txn(dd, 1'b1, 64'(ad), {$urandom, $urandom}, 1'b0, got);

    for (int dd = 0; dd < 2; dd++) begin
      txn(dd, 1'b1, 64'd8, 64'h1122334455667788, 1'b0, got);
      txn(dd, 1'b0, 64'd8, 64'd0, 1'b0, got);
      check("raw_rdata", got, 64'h1122334455667788);
      txn(dd, 1'b0, 64'd9, 64'd0, 1'b0, got);
      check("unaligned_low", {8'h00, got[55:0]}, 64'h0011223344556677);
      check("unaligned_high", 64'(got[63:56]), 64'(mem_m[dd][16]));
      txn(dd, 1'b0, 64'd1017, 64'd0, 1'b0, got);
      txn(dd, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, got);
      txn(dd, 1'b1, 64'd1017, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, got);
      txn(dd, 1'b0, 64'd1016, 64'd0, 1'b0, got);
      txn(dd, 1'b0, 64'd1010, 64'd0, 1'b0, got);
      txn(dd, 1'b0, 64'd16, 64'd0, 1'b1, got);
      txn(dd, 1'b1, 64'd24, {$urandom, $urandom}, 1'b1, got);
      txn(dd, 1'b0, 64'd24, 64'd0, 1'b1, got);
    end

    // Asynchronous reset while a write to addr 0 sits in WAIT.
    txn(0, 1'b0, 64'd40, 64'd0, 1'b0, got);
    pre = model_read(0, 64'd0);
    wait_ready(0, ok);
    if (ok) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b1;
      req_addr[0] = 64'd0; req_wdata[0] = 64'hAA;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_ready", 64'(req_ready[0]), 64'd1);
      check("arst_valid", 64'(resp_valid[0]), 64'd0);
      check("arst_rdata", resp_rdata[0], 64'd0);
      check("arst_err", 64'(dmem_error[0]), 64'd0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("aborted_no_resp", 64'(resp_valid[0]), 64'd0);
      end
      txn(0, 1'b0, 64'd0, 64'd0, 1'b0, got);
      check("aborted_no_write", got, pre);
    end

    // Randomized traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      d   = int'($urandom_range(0, 1));
      wr  = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 64'($urandom_range(0, DEPTH - 8));
      else if (sel < 8)  a = 64'($urandom_range(DEPTH - 16, DEPTH + 8));
      else               a = {$urandom, $urandom};
      txn(d, wr, a, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
